// File: rtl/ram_arb_pkg.sv
// Shared types and helpers for the round-robin RAM port arbiter.
package ram_arb_pkg;

    localparam int MAX_REQ = 8;

    // Bits needed to name one of n requesters (at least one bit).
    function automatic int owner_bits(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    typedef logic [$clog2(MAX_REQ)-1:0] owner_idx_t;

    typedef struct packed {
        logic       rd_valid;
        owner_idx_t owner_idx;
    } rd_track_t;

    typedef enum logic {
        ST_OPEN,
        ST_LOCKED
    } lock_state_t;

endpackage

// File: rtl/rr_priority_pick.sv
// Rotating-priority encoder: the first asserted request at or after start
// (wrapping modulo N) wins; returns it as one-hot and as an index.
module rr_priority_pick #(
    parameter int N  = 3,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    int          pos;
    logic [IW-1:0] pos_idx;

    // Scan offsets from farthest to nearest so the nearest request overrides.
    always_comb begin
        grant   = '0;
        idx     = '0;
        any     = 1'b0;
        pos     = 0;
        pos_idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            pos = int'(start) + k;
            if (pos >= N) begin
                pos = pos - N;
            end
            pos_idx = IW'(pos);
            if (req[pos_idx]) begin
                grant = N'(1) << pos_idx;
                idx   = pos_idx;
                any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one 2-cycle-latency single-port RAM among NUM_REQ
// requesters. Define RAM_ARB_LOCK_EN to enable the req_lock bus-lock feature.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter  int NUM_REQ   = 3,
    parameter  int WIDTH     = 8,
    parameter  int WORDS     = 2048,
    localparam int ADDR_BITS = $clog2(WORDS - 1)
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ-1:0]            req_lock,
    input  logic [NUM_REQ*ADDR_BITS-1:0]  req_addr,
    input  logic [NUM_REQ*WIDTH-1:0]      req_wdata,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [WIDTH-1:0]              rsp_data,
    output logic [ADDR_BITS-1:0]          ram_address,
    output logic                          ram_wren,
    output logic [WIDTH-1:0]              ram_write_data,
    input  logic [WIDTH-1:0]              ram_read_data
);

    localparam int IW = owner_bits(NUM_REQ);

    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
        return (i == IW'(NUM_REQ - 1)) ? '0 : i + IW'(1);
    endfunction

    logic [ADDR_BITS-1:0] addr_arr  [NUM_REQ];
    logic [WIDTH-1:0]     wdata_arr [NUM_REQ];

    logic [IW-1:0]      rr_ptr_reg, rr_ptr_next;
    rd_track_t          trk_reg [2];
    rd_track_t          trk_next;

    logic [NUM_REQ-1:0] pick_req;
    logic [IW-1:0]      pick_start;
    logic [NUM_REQ-1:0] pick_grant;
    logic [IW-1:0]      win;
    logic               pick_any;
    logic               grant_any;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
            assign addr_arr[gi]  = req_addr[gi*ADDR_BITS +: ADDR_BITS];
            assign wdata_arr[gi] = req_wdata[gi*WIDTH +: WIDTH];
            assign rsp_valid[gi] = trk_reg[1].rd_valid &&
                                   (trk_reg[1].owner_idx == owner_idx_t'(gi));
        end
    endgenerate

    rr_priority_pick #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_pick (
        .req   (pick_req),
        .start (pick_start),
        .grant (pick_grant),
        .idx   (win),
        .any   (pick_any)
    );

    // Grants are suppressed while reset is asserted so nothing reaches the RAM.
    assign req_ready      = pick_grant & {NUM_REQ{reset_n}};
    assign grant_any      = pick_any & reset_n;
    assign ram_address    = grant_any ? addr_arr[win]  : addr_arr[0];
    assign ram_write_data = grant_any ? wdata_arr[win] : wdata_arr[0];
    assign ram_wren       = grant_any & req_we[win];
    assign rsp_data       = ram_read_data;

    assign trk_next.rd_valid  = grant_any & ~req_we[win];
    assign trk_next.owner_idx = owner_idx_t'(win);

`ifdef RAM_ARB_LOCK_EN
    lock_state_t   state_reg, state_next;
    logic [IW-1:0] lock_owner_reg, lock_owner_next;
    logic          lock_hold;

    assign lock_hold  = (state_reg == ST_LOCKED) && req_lock[lock_owner_reg];
    assign pick_req   = lock_hold ? (req_valid & (NUM_REQ'(1) << lock_owner_reg)) : req_valid;
    // On the release cycle arbitration restarts just past the former owner.
    assign pick_start = lock_hold                  ? lock_owner_reg :
                        (state_reg == ST_LOCKED)   ? next_idx(lock_owner_reg) :
                                                     rr_ptr_reg;

    always_comb begin
        state_next      = state_reg;
        lock_owner_next = lock_owner_reg;
        rr_ptr_next     = rr_ptr_reg;
        if (!lock_hold) begin
            state_next = ST_OPEN;
            if (grant_any) begin
                if (req_lock[win]) begin
                    state_next      = ST_LOCKED;
                    lock_owner_next = win;
                end else begin
                    rr_ptr_next = next_idx(win);
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_reg      <= ST_OPEN;
            lock_owner_reg <= '0;
        end else begin
            state_reg      <= state_next;
            lock_owner_reg <= lock_owner_next;
        end
    end
`else
    logic unused_lock;

    assign unused_lock = ^req_lock;
    assign pick_req    = req_valid;
    assign pick_start  = rr_ptr_reg;

    always_comb begin
        rr_ptr_next = rr_ptr_reg;
        if (grant_any) begin
            rr_ptr_next = next_idx(win);
        end
    end
`endif

    // Clearing both stages on reset drops any reads still in flight.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rr_ptr_reg <= '0;
            trk_reg[0] <= '0;
            trk_reg[1] <= '0;
        end else begin
            rr_ptr_reg <= rr_ptr_next;
            trk_reg[0] <= trk_next;
            trk_reg[1] <= trk_reg[0];
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter with a behavioural 2-cycle RAM and
// a response scoreboard keyed on the cycle each read is due.
module tb_ram_port_arbiter;

    localparam int NUM_REQ = 3;
    localparam int WIDTH   = 8;
    localparam int WORDS   = 2048;
    localparam int AB      = $clog2(WORDS - 1);

    logic                   clock = 1'b0;
    logic                   reset_n;
    logic [NUM_REQ-1:0]     req_valid, req_we, req_lock;
    logic [NUM_REQ*AB-1:0]  req_addr;
    logic [NUM_REQ*WIDTH-1:0] req_wdata;
    logic [NUM_REQ-1:0]     req_ready, rsp_valid;
    logic [WIDTH-1:0]       rsp_data;
    logic [AB-1:0]          ram_address;
    logic                   ram_wren;
    logic [WIDTH-1:0]       ram_write_data, ram_read_data;

    always #5 clock = ~clock;

    ram_port_arbiter #(
        .NUM_REQ (NUM_REQ),
        .WIDTH   (WIDTH),
        .WORDS   (WORDS)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .req_valid      (req_valid),
        .req_we         (req_we),
        .req_lock       (req_lock),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_ready      (req_ready),
        .rsp_valid      (rsp_valid),
        .rsp_data       (rsp_data),
        .ram_address    (ram_address),
        .ram_wren       (ram_wren),
        .ram_write_data (ram_write_data),
        .ram_read_data  (ram_read_data)
    );

    // Single-port RAM: address registered, then data registered.
    logic [WIDTH-1:0] mem [WORDS];
    logic [AB-1:0]    rd_addr_q;
    always @(posedge clock) begin
        if (!reset_n) begin
            rd_addr_q     <= '0;
            ram_read_data <= '0;
        end else begin
            if (ram_wren) mem[ram_address] <= ram_write_data;
            rd_addr_q     <= ram_address;
            ram_read_data <= mem[rd_addr_q];
        end
    end

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    bit mon_en       = 1'b0;

    typedef struct {
        int               owner;
        logic [WIDTH-1:0] data;
        int               due;
    } exp_t;

    exp_t             sb [$];
    logic [WIDTH-1:0] shadow [WORDS];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Scoreboard: accepted reads are pushed with their due cycle, then popped.
    always @(negedge clock) begin
        exp_t          e;
        logic [AB-1:0] a;
        cyc++;
        if (mon_en) begin
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                check("rsp_valid", 32'(rsp_valid), 32'(1) << e.owner);
                check("rsp_data", 32'(rsp_data), 32'(e.data));
                $display("[TB] cycle %0d: response requester %0d data 0x%02h (expect 0x%02h)",
                         cyc, e.owner, rsp_data, e.data);
            end else begin
                check("rsp_idle", 32'(rsp_valid), 32'd0);
            end
            if (!reset_n) begin
                sb.delete();
            end else begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (req_valid[i] && req_ready[i]) begin
                        a = req_addr[i*AB +: AB];
                        if (req_we[i]) shadow[a] = req_wdata[i*WIDTH +: WIDTH];
                        else sb.push_back('{i, shadow[a], cyc + 2});
                    end
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic we,
                           input logic [AB-1:0] a, input logic [WIDTH-1:0] d);
        req_valid[i]             = v;
        req_we[i]                = we;
        req_addr[i*AB +: AB]     = a;
        req_wdata[i*WIDTH +: WIDTH] = d;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            next_cycle();
            req_valid = '0;
            req_lock  = '0;
        end
    endtask

    task automatic all_read();
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, 1'b0, AB'(16 + i), '0);
    endtask

    task automatic pulse_reset();
        next_cycle();
        req_valid = '0;
        req_lock  = '0;
        reset_n   = 1'b0;
        @(negedge clock);
        check("ready_in_reset", 32'(req_ready), 32'd0);
        next_cycle();
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n   = 1'b0;
        req_valid = '0;
        req_we    = '0;
        req_lock  = '0;
        req_addr  = '0;
        req_wdata = '0;

        // Reset, then idle for 10 cycles.
        repeat (3) next_cycle();
        mon_en = 1'b1;
        next_cycle();
        reset_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            check("idle_ready", 32'(req_ready), 32'd0);
            check("idle_wren", 32'(ram_wren), 32'd0);
            next_cycle();
        end

        // Requester 1: write 0x5A to 0x123, then read it back-to-back.
        set_req(1, 1'b1, 1'b1, AB'('h123), 8'h5A);
        @(negedge clock);
        check("wr_ready", 32'(req_ready), 32'b010);
        check("wr_wren", 32'(ram_wren), 32'd1);
        check("wr_addr", 32'(ram_address), 32'h123);
        check("wr_data", 32'(ram_write_data), 32'h5A);
        next_cycle();
        set_req(1, 1'b1, 1'b0, AB'('h123), '0);
        @(negedge clock);
        check("rd_ready", 32'(req_ready), 32'b010);
        check("rd_wren", 32'(ram_wren), 32'd0);
        idle(4);

        // Preload 0x010+i with 0xA0+i through requester 0.
        for (int i = 0; i < NUM_REQ; i++) begin
            next_cycle();
            set_req(0, 1'b1, 1'b1, AB'(16 + i), WIDTH'(8'hA0 + i));
            @(negedge clock);
            check("preload_ready", 32'(req_ready), 32'b001);
        end
        idle(3);

        // All requesters reading continuously: strict rotation from 0.
        pulse_reset();
        for (int k = 0; k < 6; k++) begin
            next_cycle();
            all_read();
            @(negedge clock);
            check("rotate", 32'(req_ready), 32'(1) << (k % NUM_REQ));
        end
        idle(4);

        // Read in flight when reset pulses must never respond.
        next_cycle();
        set_req(2, 1'b1, 1'b0, AB'(18), '0);
        @(negedge clock);
        check("flush_accept", 32'(req_ready), 32'b100);
        next_cycle();
        reset_n = 1'b0;
        all_read();
        @(negedge clock);
        check("flush_ready_in_reset", 32'(req_ready), 32'd0);
        next_cycle();
        reset_n = 1'b1;
        @(negedge clock);
        check("post_reset_first", 32'(req_ready), 32'b001);
        idle(4);

        // Single requester granted every cycle, pointer wraps to 0.
        for (int k = 0; k < 5; k++) begin
            next_cycle();
            req_valid = '0;
            set_req(2, 1'b1, 1'b0, AB'(18), '0);
            @(negedge clock);
            check("solo_grant", 32'(req_ready), 32'b100);
        end
        next_cycle();
        all_read();
        @(negedge clock);
        check("wrap_to_0", 32'(req_ready), 32'b001);
        idle(4);

`ifdef RAM_ARB_LOCK_EN
        // Requester 0 locks the port; others wait until the lock drops.
        pulse_reset();
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            all_read();
            req_lock = 3'b001;
            @(negedge clock);
            check("lock_grant", 32'(req_ready), 32'b001);
        end
        next_cycle();
        req_valid[0] = 1'b0;
        @(negedge clock);
        check("lock_owner_idle", 32'(req_ready), 32'd0);
        next_cycle();
        req_lock = '0;
        @(negedge clock);
        check("lock_release", 32'(req_ready), 32'b010);
        idle(4);
`endif

        for (int k = 0; k < 10 && sb.size() > 0; k++) next_cycle();
        check("drain", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
